// File: rtl/xy_router_multi_plane.sv
// Multi-plane 2D-mesh XY router with per-input FIFOs and per-output round-robin arbitration.
// Latency: a flit pushed in cycle N is offered on its output in cycle N+1 when uncontended.
// Backpressure: in_tready_o drops when an input FIFO fills; a stalled output holds its flit and grant.
// Optional: define XY_ROUTER_PMU_EN to enable the per-output 32-bit flit counters on pmu_flits_o.

// Generic synchronous FIFO; the head entry is readable combinationally.
module xy_router_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head_dat = mem[rd_ptr[AW-1:0]];

  // Pointer update; push is refused while full even if a pop happens in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents are don't-care until pointed at, so no reset.
  always_ff @(posedge clk_i) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

module xy_router_multi_plane #(
  parameter int PLANES          = 2,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int ROUTER_X        = 0,
  parameter int ROUTER_Y        = 0,
  parameter int MAX_ROUTERS_X   = 4,
  parameter int MAX_ROUTERS_Y   = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [PLANES*5*AXIS_DATA_WIDTH-1:0] in_tdata_i,
  input  logic [PLANES*5-1:0]                 in_tvalid_i,
  input  logic [PLANES*5-1:0]                 in_tlast_i,
  output logic [PLANES*5-1:0]                 in_tready_o,
  output logic [PLANES*5*AXIS_DATA_WIDTH-1:0] out_tdata_o,
  output logic [PLANES*5-1:0]                 out_tvalid_o,
  output logic [PLANES*5-1:0]                 out_tlast_o,
  input  logic [PLANES*5-1:0]                 out_tready_i,
  output logic [PLANES*5*32-1:0]              pmu_flits_o
);
  localparam int D  = AXIS_DATA_WIDTH;
  localparam int XW = ($clog2(MAX_ROUTERS_X) > 1) ? $clog2(MAX_ROUTERS_X) : 1;
  localparam int YW = ($clog2(MAX_ROUTERS_Y) > 1) ? $clog2(MAX_ROUTERS_Y) : 1;
  localparam logic [XW-1:0] RX = XW'(ROUTER_X);
  localparam logic [YW-1:0] RY = YW'(ROUTER_Y);

  localparam logic [2:0] P_HOME  = 3'd0;
  localparam logic [2:0] P_NORTH = 3'd1;
  localparam logic [2:0] P_EAST  = 3'd2;
  localparam logic [2:0] P_SOUTH = 3'd3;
  localparam logic [2:0] P_WEST  = 3'd4;

  typedef enum logic {HEAD, BODY} in_state_t;

  function automatic logic [2:0] rr_next(input logic [2:0] x);
    return (x == 3'd4) ? 3'd0 : x + 3'd1;
  endfunction

  for (genvar p = 0; p < PLANES; p++) begin : g_plane
    logic [D-1:0] head_dat [5];
    logic [2:0]   route_sel [5];
    logic [2:0]   out_sel [5];
    logic [4:0]   head_last;
    logic [4:0]   fifo_full;
    logic [4:0]   fifo_empty;
    logic [4:0]   pop;
    logic [4:0]   xfer;

    // Each transferring output pops the FIFO of the input it currently selects.
    always_comb begin
      pop = '0;
      for (int o = 0; o < 5; o++) begin
        if (xfer[o]) pop[out_sel[o]] = 1'b1;
      end
    end

    for (genvar k = 0; k < 5; k++) begin : g_in
      localparam int I = p*5 + k;
      logic [D:0]    head_word;
      logic [XW-1:0] dx;
      logic [YW-1:0] dy;
      logic [2:0]    route_hdr;
      logic [2:0]    route_q;
      in_state_t     state_q;
      in_state_t     state_d;

      xy_router_fifo #(.W(D+1), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push     (in_tvalid_i[I] && in_tready_o[I]),
        .push_dat ({in_tlast_i[I], in_tdata_i[I*D +: D]}),
        .pop      (pop[k]),
        .head_dat (head_word),
        .full     (fifo_full[k]),
        .empty    (fifo_empty[k])
      );

      assign in_tready_o[I] = !fifo_full[k] && !rst_i;
      assign head_dat[k]    = head_word[D-1:0];
      assign head_last[k]   = head_word[D];
      assign dx             = head_word[XW-1:0];
      assign dy             = head_word[XW+YW-1:XW];
      assign route_sel[k]   = (state_q == BODY) ? route_q : route_hdr;

      // Dimension-ordered route of the head flit: X first, then Y.
      always_comb begin
        route_hdr = P_HOME;
        if (dx > RX)      route_hdr = P_EAST;
        else if (dx < RX) route_hdr = P_WEST;
        else if (dy > RY) route_hdr = P_SOUTH;
        else if (dy < RY) route_hdr = P_NORTH;
      end

      // Packet-position state register.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= HEAD;
        else       state_q <= state_d;
      end

      // Next packet position: a transferred tlast flit ends the packet.
      always_comb begin
        state_d = state_q;
        if (pop[k]) state_d = head_last[k] ? HEAD : BODY;
      end

      // Latch the header's route so body flits follow it.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                         route_q <= P_HOME;
        else if (pop[k] && state_q == HEAD) route_q <= route_hdr;
      end
    end

    for (genvar o = 0; o < 5; o++) begin : g_out
      localparam int O = p*5 + o;
      logic [4:0] req;
      logic       lock_q;
      logic [2:0] idx_q;
      logic [2:0] ptr_q;
      logic [2:0] pick;
      logic       pick_vld;
      logic [3:0] cand;
      logic       vld;

      // Requests from inputs whose current route targets this output.
      always_comb begin
        req = '0;
        for (int k = 0; k < 5; k++) req[k] = !fifo_empty[k] && (route_sel[k] == 3'(o));
      end

      // Round-robin pick: scan downward so the requester nearest the pointer wins.
      always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int i = 4; i >= 0; i--) begin
          cand = {1'b0, ptr_q} + 4'(i);
          if (cand > 4'd4) cand = cand - 4'd5;
          if (req[cand[2:0]]) begin
            pick     = cand[2:0];
            pick_vld = 1'b1;
          end
        end
      end

      assign out_sel[o] = lock_q ? idx_q : pick;
      assign vld        = (lock_q || pick_vld) && !fifo_empty[out_sel[o]];
      assign xfer[o]    = vld && out_tready_i[O];

      assign out_tvalid_o[O]        = vld;
      assign out_tlast_o[O]         = vld && head_last[out_sel[o]];
      assign out_tdata_o[O*D +: D]  = vld ? head_dat[out_sel[o]] : '0;

      // Grant is taken as soon as a header is offered (keeps a stalled flit stable)
      // and released on the tlast transfer, advancing the pointer past the winner.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          lock_q <= 1'b0;
          idx_q  <= '0;
          ptr_q  <= '0;
        end else if (lock_q) begin
          if (xfer[o] && head_last[idx_q]) begin
            lock_q <= 1'b0;
            ptr_q  <= rr_next(idx_q);
          end
        end else if (pick_vld) begin
          if (xfer[o] && head_last[pick]) begin
            ptr_q <= rr_next(pick);
          end else begin
            lock_q <= 1'b1;
            idx_q  <= pick;
          end
        end
      end

`ifdef XY_ROUTER_PMU_EN
      logic [31:0] cnt_q;
      // Free-running transfer counter, wraps naturally at 2^32.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        cnt_q <= '0;
        else if (xfer[o]) cnt_q <= cnt_q + 32'd1;
      end
      assign pmu_flits_o[O*32 +: 32] = cnt_q;
`endif
    end
  end

`ifndef XY_ROUTER_PMU_EN
  assign pmu_flits_o = '0;
`endif
endmodule

// File: tb/tb_xy_router_multi_plane.sv
// Testbench for xy_router_multi_plane at router (1,1): directed scenarios then random traffic.
// Checks against a route/scoreboard model; outputs sampled 1 time unit after the falling edge.
// Backpressure is exercised by held and randomized out_tready_i.
module tb_xy_router_multi_plane;
  localparam int P = 2;
  localparam int D = 32;
  localparam int N = P*5;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic [N*D-1:0] in_tdata_i = '0;
  logic [N-1:0]   in_tvalid_i = '0;
  logic [N-1:0]   in_tlast_i = '0;
  logic [N-1:0]   in_tready_o;
  logic [N*D-1:0] out_tdata_o;
  logic [N-1:0]   out_tvalid_o;
  logic [N-1:0]   out_tlast_o;
  logic [N-1:0]   out_tready_i = '1;
  logic [N*32-1:0] pmu_flits_o;

  always #5 clk_i = ~clk_i;

  xy_router_multi_plane #(
    .PLANES(P), .AXIS_DATA_WIDTH(D), .FIFO_DEPTH(4),
    .ROUTER_X(1), .ROUTER_Y(1), .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .in_tdata_i(in_tdata_i), .in_tvalid_i(in_tvalid_i), .in_tlast_i(in_tlast_i),
    .in_tready_o(in_tready_o),
    .out_tdata_o(out_tdata_o), .out_tvalid_o(out_tvalid_o), .out_tlast_o(out_tlast_o),
    .out_tready_i(out_tready_i), .pmu_flits_o(pmu_flits_o)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic        last;
    logic [31:0] dat;
  } obs_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int seq_ctr = 0;
  logic [31:0] pend_dat [N][$];
  logic        pend_last [N][$];
  obs_t        log_q [N][$];
  logic [32:0] exp_q [N*N][$];
  logic [N-1:0] ordy = '1;
  bit          rand_valid = 0;
  bit          rand_ordy = 0;
  bit          hold [N];
  logic [32:0] hold_val [N];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // XY routing rule for router (1,1): 0 HOME, 1 NORTH, 2 EAST, 3 SOUTH, 4 WEST.
  function automatic int ref_route(input int dx, input int dy);
    if (dx > 1) return 2;
    if (dx < 1) return 4;
    if (dy > 1) return 3;
    if (dy < 1) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] mk(input int src, input int seq, input int dx, input int dy);
    return {16'(seq), 8'(src), 4'h0, 2'(dy), 2'(dx)};
  endfunction

  task automatic send_pkt(input int src, input int len, input int dx, input int dy);
    int out;
    logic [31:0] d;
    out = (src/5)*5 + ref_route(dx, dy);
    for (int f = 0; f < len; f++) begin
      d = mk(src, seq_ctr, dx, dy);
      seq_ctr++;
      pend_dat[src].push_back(d);
      pend_last[src].push_back(f == len-1);
      exp_q[src*N + out].push_back({f == len-1, d});
    end
  endtask

  function automatic int pend_total();
    int t = 0;
    for (int i = 0; i < N; i++) t += pend_dat[i].size();
    return t;
  endfunction

  task automatic clear_logs();
    for (int o = 0; o < N; o++) log_q[o].delete();
  endtask

  // One clock: drive at the falling edge, then sample what the next rising edge will transfer.
  task automatic step();
    @(negedge clk_i);
    for (int i = 0; i < N; i++) begin
      if (pend_dat[i].size() > 0 && (!rand_valid || $urandom_range(0, 3) != 0)) begin
        in_tvalid_i[i]         = 1'b1;
        in_tdata_i[i*D +: D]   = pend_dat[i][0];
        in_tlast_i[i]          = pend_last[i][0];
      end else begin
        in_tvalid_i[i]         = 1'b0;
        in_tdata_i[i*D +: D]   = '0;
        in_tlast_i[i]          = 1'b0;
      end
      out_tready_i[i] = rand_ordy ? ($urandom_range(0, 2) != 0) : ordy[i];
    end
    #1;
    for (int o = 0; o < N; o++) begin
      if (hold[o])
        check("stall_stable", {out_tvalid_o[o], out_tlast_o[o], out_tdata_o[o*D +: D]},
              {1'b1, hold_val[o]});
      if (!out_tvalid_o[o])
        check("idle_zero", {out_tlast_o[o], out_tdata_o[o*D +: D]}, '0);
      hold[o]     = out_tvalid_o[o] && !out_tready_i[o];
      hold_val[o] = {out_tlast_o[o], out_tdata_o[o*D +: D]};
      if (out_tvalid_o[o] && out_tready_i[o])
        log_q[o].push_back({32'(cyc), out_tlast_o[o], out_tdata_o[o*D +: D]});
    end
    for (int i = 0; i < N; i++) begin
      if (in_tvalid_i[i] && in_tready_o[i]) begin
        void'(pend_dat[i].pop_front());
        void'(pend_last[i].pop_front());
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i       = 1'b1;
    in_tvalid_i = '0;
    in_tlast_i  = '0;
    in_tdata_i  = '0;
    for (int i = 0; i < N; i++) begin
      pend_dat[i].delete();
      pend_last[i].delete();
      hold[i] = 0;
    end
    for (int i = 0; i < N*N; i++) exp_q[i].delete();
    clear_logs();
    #1;
    check("rst_in_tready", in_tready_o, '0);
    check("rst_out_tvalid", out_tvalid_o, '0);
    check("rst_pmu", |pmu_flits_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("in_tready_after_rst", in_tready_o, {N{1'b1}});
  endtask

  initial begin
    logic [31:0] t_dat [6];
    logic [31:0] ord [$];
    int c0;
    int guard;
    int remain;
    int cur;
    int src;
    int key;
    obs_t e;
    logic [33:0] ev;

    for (int i = 0; i < N; i++) hold[i] = 0;
    do_reset();

    // Single 3-flit packet HOME -> EAST, one-cycle latency, tlast on flit 3 only.
    ordy = '1;
    send_pkt(0, 3, 3, 1);
    for (int f = 0; f < 3; f++) t_dat[f] = pend_dat[0][f];
    c0 = cyc;
    repeat (6) step();
    check("t1_count", log_q[2].size(), 3);
    if (log_q[2].size() >= 3) begin
      for (int f = 0; f < 3; f++) begin
        check("t1_cycle", log_q[2][f].cyc, 32'(c0 + 1 + f));
        check("t1_data", log_q[2][f].dat, t_dat[f]);
        check("t1_last", log_q[2][f].last, (f == 2));
      end
    end

    // Three inputs contend for HOME; pointer starts at 0.
    clear_logs();
    send_pkt(1, 2, 1, 1);
    send_pkt(4, 2, 1, 1);
    send_pkt(0, 2, 1, 1);
    ord.delete();
    ord.push_back(pend_dat[0][0]); ord.push_back(pend_dat[0][1]);
    ord.push_back(pend_dat[1][0]); ord.push_back(pend_dat[1][1]);
    ord.push_back(pend_dat[4][0]); ord.push_back(pend_dat[4][1]);
    repeat (10) step();
    check("t2_count", log_q[0].size(), 6);
    if (log_q[0].size() >= 6)
      for (int j = 0; j < 6; j++) check("t2_order", log_q[0][j].dat, ord[j]);

    // Next round: pointer is past WEST (0), so NORTH beats SOUTH.
    clear_logs();
    send_pkt(3, 2, 1, 1);
    send_pkt(1, 2, 1, 1);
    ord.delete();
    ord.push_back(pend_dat[1][0]); ord.push_back(pend_dat[1][1]);
    ord.push_back(pend_dat[3][0]); ord.push_back(pend_dat[3][1]);
    repeat (8) step();
    check("t2b_count", log_q[0].size(), 4);
    if (log_q[0].size() >= 4)
      for (int j = 0; j < 4; j++) check("t2b_order", log_q[0][j].dat, ord[j]);

    // EAST stalled: 4 flits fill the FIFO, head stays stable, all 6 drain afterwards.
    clear_logs();
    ordy[2] = 1'b0;
    send_pkt(0, 6, 3, 1);
    for (int f = 0; f < 6; f++) t_dat[f] = pend_dat[0][f];
    repeat (8) step();
    check("t3_accepted", 6 - pend_dat[0].size(), 4);
    check("t3_in_tready", in_tready_o[0], 1'b0);
    check("t3_out_valid", out_tvalid_o[2], 1'b1);
    check("t3_head_data", out_tdata_o[2*D +: D], t_dat[0]);
    ordy[2] = 1'b1;
    repeat (10) step();
    check("t3_count", log_q[2].size(), 6);
    if (log_q[2].size() >= 6) begin
      for (int f = 0; f < 6; f++) begin
        check("t3_data", log_q[2][f].dat, t_dat[f]);
        check("t3_last", log_q[2][f].last, (f == 5));
      end
    end

    // Same route on both planes; plane 1 stalled must not disturb plane 0.
    clear_logs();
    ordy[7] = 1'b0;
    send_pkt(0, 3, 3, 1);
    send_pkt(5, 3, 3, 1);
    c0 = cyc;
    repeat (6) step();
    check("t4_p0_count", log_q[2].size(), 3);
    if (log_q[2].size() >= 3) check("t4_p0_last_cycle", log_q[2][2].cyc, 32'(c0 + 3));
    check("t4_p1_blocked", log_q[7].size(), 0);
    ordy[7] = 1'b1;
    repeat (6) step();
    check("t4_p1_count", log_q[7].size(), 3);

    // Reset mid-packet: the next flit is a header routed to WEST.
    clear_logs();
    send_pkt(0, 4, 3, 1);
    step();
    step();
    do_reset();
    send_pkt(0, 1, 0, 0);
    t_dat[0] = pend_dat[0][0];
    repeat (5) step();
    check("t5_west_count", log_q[4].size(), 1);
    if (log_q[4].size() >= 1) begin
      check("t5_west_data", log_q[4][0].dat, t_dat[0]);
      check("t5_west_last", log_q[4][0].last, 1'b1);
    end
    remain = 0;
    for (int o = 0; o < N; o++) remain += log_q[o].size();
    check("t5_total_flits", remain, 1);

    // 10 flits through plane 1 SOUTH, back to back.
    clear_logs();
    send_pkt(5, 5, 1, 3);
    send_pkt(5, 5, 1, 3);
    repeat (16) step();
    check("t6_count", log_q[8].size(), 10);
    if (log_q[8].size() >= 10) check("t6_throughput", log_q[8][9].cyc - log_q[8][0].cyc, 9);
`ifdef XY_ROUTER_PMU_EN
    check("t6_pmu", pmu_flits_o[8*32 +: 32], 32'd10);
`else
    check("t6_pmu", pmu_flits_o[8*32 +: 32], 32'd0);
`endif

    // Random traffic against the scoreboard.
    do_reset();
    for (int n = 0; n < 80; n++)
      send_pkt($urandom_range(0, N-1), $urandom_range(1, 4), $urandom_range(0, 3), $urandom_range(0, 3));
    rand_valid = 1;
    rand_ordy  = 1;
    guard = 0;
    while (pend_total() != 0 && guard < 4000) begin
      step();
      guard++;
    end
    check("rnd_inputs_drained", pend_total(), 0);
    rand_valid = 0;
    rand_ordy  = 0;
    ordy       = '1;
    repeat (30) step();
    for (int o = 0; o < N; o++) begin
      cur = -1;
      while (log_q[o].size() > 0) begin
        e   = log_q[o].pop_front();
        src = (cur >= 0) ? cur : int'(e.dat[15:8]);
        if (src >= N) src = 0;
        key = src*N + o;
        ev  = (exp_q[key].size() > 0) ? {1'b0, exp_q[key].pop_front()} : 34'h3_0000_0000;
        check("rnd_flit", {1'b0, e.last, e.dat}, ev);
        cur = e.last ? -1 : src;
      end
    end
    remain = 0;
    for (int i = 0; i < N*N; i++) remain += exp_q[i].size();
    check("rnd_all_delivered", remain, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
